// File: rtl/alu_share_pkg.sv
// Shared types and opcode helpers for the shared-ALU controller.
package alu_share_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_LSA = 4'b0110,
    OP_RSA = 4'b0111,
    OP_LSL = 4'b1000,
    OP_RSL = 4'b1001,
    OP_DIV = 4'b1010,
    OP_SIN = 4'b1011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_LAST_LEGAL = 4'b1011;

  // Long combinational paths that need the multicycle hold window.
  function automatic logic is_multicycle(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_SIN);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and encoded index, pointer advances on accept.
module alu_rr_arbiter #(
  parameter int unsigned REQ = 4,
  localparam int unsigned IDW = $clog2(REQ)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [REQ-1:0] req,
  output logic [REQ-1:0] gnt_c,
  output logic [IDW-1:0] idx_c
);

  logic [IDW-1:0] ptr;
  logic           found;

  // Search starts at the pointer and wraps once around all requesters.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    for (int i = 0; i < int'(REQ); i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= int'(REQ)) j = j - int'(REQ);
      if (en && !found && req[IDW'(j)]) begin
        found          = 1'b1;
        gnt_c[IDW'(j)] = 1'b1;
        idx_c          = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx_c == IDW'(REQ - 1)) ? '0 : idx_c + 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU among REQ requesters with a multicycle hold for DIV/SIN.
// Optional illegal-opcode trap: define ALU_SHARE_OPCHECK_EN.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned REQ       = 4,
  parameter int unsigned MC_CYCLES = 4,
  localparam int unsigned IDW      = $clog2(REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ-1:0]          req_valid,
  output logic [REQ-1:0]          req_ready,
  input  logic [REQ-1:0][N-1:0]   req_a,
  input  logic [REQ-1:0][N-1:0]   req_b,
  input  logic [REQ-1:0][3:0]     req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [N-1:0]            rsp_result,
  output logic [3:0]              rsp_flags,
  output logic                    rsp_err,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [3:0]              alu_ctrl,
  input  logic [N-1:0]            alu_result,
  input  logic [3:0]              alu_flags,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(MC_CYCLES + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [REQ-1:0] gnt_c;
  logic [IDW-1:0] idx_c;
  logic           accept_c;
  logic [3:0]     op_sel_c;
  logic           skip_c;

  alu_rr_arbiter #(.REQ(REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    ((state == IDLE) && !rst),
    .req   (req_valid),
    .gnt_c (gnt_c),
    .idx_c (idx_c)
  );

  assign req_ready = gnt_c;
  assign accept_c  = |gnt_c;
  assign op_sel_c  = req_op[idx_c];

`ifdef ALU_SHARE_OPCHECK_EN
  assign skip_c = !is_legal_op(op_sel_c);
`else
  assign skip_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            rsp_id <= idx_c;
            busy   <= 1'b1;
            if (skip_c) begin
              // Trapped opcode bypasses the ALU and answers immediately.
              cnt        <= '0;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a    <= req_a[idx_c];
              alu_b    <= req_b[idx_c];
              alu_ctrl <= op_sel_c;
              cnt      <= is_multicycle(alu_op_t'(op_sel_c)) ? CW'(MC_CYCLES - 1) : '0;
              rsp_err  <= 1'b0;
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU on the alu_* port.
module tb_alu_share_ctrl;

  localparam int N   = 8;
  localparam int REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REQ-1:0]        req_valid;
  logic [REQ-1:0]        req_ready;
  logic [REQ-1:0][N-1:0] req_a;
  logic [REQ-1:0][N-1:0] req_b;
  logic [REQ-1:0][3:0]   req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [N-1:0]          rsp_result;
  logic [3:0]            rsp_flags;
  logic                  rsp_err;
  logic [N-1:0]          alu_a;
  logic [N-1:0]          alu_b;
  logic [3:0]            alu_ctrl;
  logic [N-1:0]          alu_result;
  logic [3:0]            alu_flags;
  logic                  busy;

  always #5 clk = ~clk;

  alu_share_ctrl #(.N(N), .REQ(REQ), .MC_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy)
  );

  // Behavioural ALU: flags echo the opcode so the captured flags are traceable.
  always_comb begin
    alu_flags = alu_ctrl;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b1010: alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
      4'b1011: alu_result = 8'h5A;
      default: alu_result = 8'hA5;
    endcase
  end

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] res, input logic [3:0] flags,
                      input logic err);
    exp_t e;
    e.id = id; e.res = res; e.flags = flags; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: every response handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id",     32'(rsp_id),     32'(mon_e.id));
        check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        check("rsp_flags",  32'(rsp_flags),  32'(mon_e.flags));
        check("rsp_err",    32'(rsp_err),    32'(mon_e.err));
      end
    end
  end

  task automatic wait_accept(input logic [1:0] id);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    check("accept", 32'(got), 32'(1));
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) got = 1;
    end
    check("idle", 32'(got), 32'(1));
    @(posedge clk); #1;
  endtask

  // Issue one op with rsp_ready high and measure cycles from accept to rsp_valid.
  task automatic run_op(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input int exp_lat, input logic [7:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_err, input bit to_alu);
    int n = 0;
    bit got = 0;
    push(id, exp_res, exp_flags, exp_err);
    req_a[id] = a; req_b[id] = b; req_op[id] = op; req_valid[id] = 1'b1;
    wait_accept(id);
    @(posedge clk); #1 req_valid[id] = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; n = k;
      end else if (to_alu) begin
        check("alu_ctrl_hold", 32'(alu_ctrl), 32'(op));
      end
    end
    check("latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int last;
    bit got;
    bit seen;
    logic [7:0] held_res;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",      32'(busy),       32'(0));
    check("rst_rsp_valid", 32'(rsp_valid),  32'(0));
    check("rst_req_ready", 32'(req_ready),  32'(0));
    check("rst_rsp_id",    32'(rsp_id),     32'(0));
    check("rst_result",    32'(rsp_result), 32'(0));
    check("rst_flags",     32'(rsp_flags),  32'(0));
    check("rst_err",       32'(rsp_err),    32'(0));
    check("rst_alu_a",     32'(alu_a),      32'(0));
    check("rst_alu_ctrl",  32'(alu_ctrl),   32'(0));
    @(posedge clk); #1;

    run_op(2'd0, 8'd4,   8'd2,   4'b0000, 2, 8'd6,   4'b0000, 1'b0, 1);
    run_op(2'd1, 8'd8,   8'd2,   4'b1010, 5, 8'd4,   4'b1010, 1'b0, 1);
    run_op(2'd2, 8'd5,   8'd7,   4'b0001, 2, 8'hFE,  4'b0001, 1'b0, 1);
    run_op(2'd3, 8'hF0,  8'h3C,  4'b0100, 2, 8'hCC,  4'b0100, 1'b0, 1);
    run_op(2'd0, 8'd1,   8'd1,   4'b1011, 5, 8'h5A,  4'b1011, 1'b0, 1);
`ifdef ALU_SHARE_OPCHECK_EN
    run_op(2'd1, 8'd1,   8'd2,   4'b1110, 1, 8'h00,  4'b0000, 1'b1, 0);
    check("illegal_alu_ctrl_kept", 32'(alu_ctrl), 32'(4'b1011));
`else
    run_op(2'd1, 8'd1,   8'd2,   4'b1110, 2, 8'hA5,  4'b1110, 1'b0, 1);
`endif
    wait_idle();

    // Backpressure: response held while a second requester waits.
    rsp_ready = 1'b0;
    push(2'd2, 8'h1E, 4'b0000, 1'b0);
    req_a[2] = 8'd10; req_b[2] = 8'd20; req_op[2] = 4'b0000; req_valid[2] = 1'b1;
    wait_accept(2'd2);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    push(2'd1, 8'd2, 4'b0000, 1'b0);
    req_a[1] = 8'd1; req_b[1] = 8'd1; req_op[1] = 4'b0000; req_valid[1] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    check("bp_rsp_valid_seen", 32'(got), 32'(1));
    held_res = rsp_result;
    check("bp_result_value", 32'(held_res), 32'(8'h1E));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 32'(rsp_valid),  32'(1));
      check("bp_result_stable",  32'(rsp_result), 32'(held_res));
      check("bp_id_stable",      32'(rsp_id),     32'(2));
      check("bp_req_ready_zero", 32'(req_ready),  32'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_resume_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_idle();

    // Fairness from a fresh reset: pointer restarts at requester 0.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < REQ; i++) begin
      req_a[i] = 8'(i + 1); req_b[i] = 8'd10; req_op[i] = 4'b0000;
    end
    for (int k = 0; k < 6; k++) push(2'(order[k]), 8'(order[k] + 11), 4'b0000, 1'b0);
    req_valid = 4'b1111;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      got = 0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (|req_ready) got = 1;
      end
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << order[k]));
      if (k > 0) check("rr_gap", 32'(cyc - last), 32'(3));
      last = cyc;
      @(posedge clk);
    end
    #1 req_valid = '0;
    wait_idle();

    // Reset during DIV EXEC drops the transaction and clears the pointer.
    req_a[1] = 8'd9; req_b[1] = 8'd3; req_op[1] = 4'b1010; req_valid[1] = 1'b1;
    wait_accept(2'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_busy",      32'(busy),       32'(0));
    check("mrst_rsp_valid", 32'(rsp_valid),  32'(0));
    check("mrst_alu_ctrl",  32'(alu_ctrl),   32'(0));
    check("mrst_alu_a",     32'(alu_a),      32'(0));
    check("mrst_result",    32'(rsp_result), 32'(0));
    check("mrst_rsp_id",    32'(rsp_id),     32'(0));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1;
    end
    check("mrst_no_response", 32'(seen), 32'(0));
    @(posedge clk); #1;
    push(2'd0, 8'd14, 4'b0000, 1'b0);
    push(2'd3, 8'd3,  4'b0000, 1'b0);
    req_a[0] = 8'd7; req_b[0] = 8'd7; req_op[0] = 4'b0000;
    req_a[3] = 8'd1; req_b[3] = 8'd2; req_op[3] = 4'b0000;
    req_valid = 4'b1001;
    @(negedge clk);
    check("mrst_first_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_accept(2'd3);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_idle();

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that shares one combinational `ALU_N_bits` instance among several requesters. It arbitrates round-robin, latches the winner's operands and opcode onto the ALU inputs, and holds them for a multicycle window on long-path ops (DIV, SIN). It captures result and flags, then returns them through a valid/ready response port. It sits between the processor's execute-side clients (core, 2D graphics units) and the shared ALU.

## Interface
- `N`, 8, ALU data width.
- `REQ`, 4, number of requesters, at least 2; `IDW = $clog2(REQ)`.
- `MC_CYCLES`, 4, number of EXEC cycles for DIV/SIN, at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  REQ  per-requester request.
- `req_ready`  out  REQ  one-hot accept strobe.
- `req_a`, `req_b`  in  REQ×N  per-requester operands.
- `req_op`  in  REQ×4  per-requester ALUControl code.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester being answered.
- `rsp_result`  out  N  captured ALU result.
- `rsp_flags`  out  4  captured ALU flags.
- `rsp_err`  out  1  illegal opcode (see Configuration).
- `alu_a`, `alu_b`  out  N  operands to the ALU.
- `alu_ctrl`  out  4  ALUControl to the ALU.
- `alu_result`  in  N  result from the ALU.
- `alu_flags`  in  4  flags from the ALU.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Opcodes: ADD 0000, SUB 0001, AND 0010, ORR 0011, XOR 0100, NOT 0101, LSA 0110, RSA 0111, LSL 1000, RSL 1001, DIV 1010, SIN 1011. DIV and SIN are multicycle; all others take one cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready` is the round-robin grant over `req_valid`. It is combinational, at most one bit high, and all-zero outside IDLE.
  - On handshake: latch `req_a[g]`, `req_b[g]`, `req_op[g]` into `alu_a`, `alu_b`, `alu_ctrl`; latch `g` into `rsp_id`; load the counter with L-1, where L = MC_CYCLES for DIV/SIN and 1 otherwise; go to EXEC.
- EXEC:
  - ALU inputs are held constant.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, capture `alu_result` and `alu_flags` into `rsp_result` and `rsp_flags`, then go to RESP.
- RESP:
  - `rsp_valid` is 1.
  - `rsp_id`, `rsp_result`, `rsp_flags` and `rsp_err` are stable until `rsp_valid & rsp_ready`.
  - On that handshake go to IDLE.
- Round-robin: the pointer starts at 0. After a grant to g, the pointer becomes (g+1) mod REQ. The search begins at the pointer and wraps. A requester with `req_valid` held high waits at most REQ-1 grants.
- Requesters hold `req_a`, `req_b`, `req_op` stable while `req_valid` is high and not yet accepted. Deasserting `req_valid` before acceptance is permitted and is not an error.
- `alu_*` keep their last latched values in IDLE and RESP.
- Reset values: state IDLE; pointer 0; counter 0; `rsp_valid` 0; `rsp_id` 0; `rsp_result` 0; `rsp_flags` 0; `rsp_err` 0; `alu_a`, `alu_b`, `alu_ctrl` 0; `busy` 0; `req_ready` 0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is produced, and all registers return to reset values on the next edge.

## Timing
- Accept at cycle T.
- Single-cycle op: EXEC at T+1, `rsp_valid` from T+2.
- DIV/SIN: EXEC at T+1 through T+MC_CYCLES, `rsp_valid` from T+MC_CYCLES+1.
- Response handshake at cycle R: IDLE at R+1, earliest next accept at R+1.
- Peak throughput is one single-cycle op per 3 cycles.
- `rsp_ready` held low stalls indefinitely with outputs stable.

## Configuration
- Macro `ALU_SHARE_OPCHECK_EN`.
  - Defined: an opcode in 1100–1111 is accepted but skips EXEC. It goes to RESP at T+1 with `rsp_err=1`, `rsp_result=0`, `rsp_flags=0`, and the `alu_*` outputs unchanged.
  - Undefined: `rsp_err` is tied 0, and every opcode is forwarded to the ALU as a single-cycle op.

## Structure
- Package `alu_share_pkg`:
  - `alu_op_t` enum with the 4-bit codes above.
  - `state_t` enum (IDLE, EXEC, RESP).
  - Function `is_multicycle(alu_op_t)`.
  - Function `is_legal_op(logic [3:0])`.
- Sub-module `alu_rr_arbiter`: parameterised by REQ; holds the pointer register, produces the one-hot grant and encoded index, and advances the pointer on an accept strobe.
- The top instantiates the arbiter and contains the FSM, counter and capture registers. The ALU is external.

## Test plan
- Single ADD: requester 0 sends A=4, B=2, op 0000, `rsp_ready=1`, accepted at T → `rsp_valid` at T+2, `rsp_id=0`, `rsp_result=6`.
- DIV with MC_CYCLES=4: A=8, B=2, op 1010 → `alu_ctrl=1010` stable T+1..T+4, response at T+5 with result 4.
- Fairness: all four `req_valid` high continuously, `rsp_ready=1` → grant order 0,1,2,3,0,1; each gap between accepts is 3 cycles.
- Backpressure: `rsp_ready=0` for 5 cycles during RESP → `rsp_valid` held, result and id unchanged, `req_ready` all 0; accept resumes the cycle after `rsp_ready` rises.
- Reset during DIV EXEC (cycle T+2) → next cycle `busy=0`, all outputs 0, no `rsp_valid` ever for that request, next grant goes to requester 0.
- Illegal op 1110: with the macro, `rsp_valid` at T+1, `rsp_err=1`, result 0; without it, response at T+2 with `rsp_err=0`.
